// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence generator and its checker.
package fib_pkg;

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fib_state_t;

    localparam int FIB_SEED      = 1;
    localparam int FIB_W_DEFAULT = 4;
    localparam int FIB_N_DEFAULT = 10;

endpackage

// File: rtl/fib_ref_model.sv
// Golden Fibonacci model: two history registers and the expected-value adder.
module fib_ref_model
    import fib_pkg::*;
#(
    parameter int W = FIB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] expected
);

    logic [W-1:0] g1_r;
    logic [W-1:0] g2_r;

    // An all-zero history only occurs before the first accept; after one seed
    // accept (g1=1, g2=0) the plain sum already yields the second seed.
    always_comb begin
        if ((g1_r == {W{1'b0}}) && (g2_r == {W{1'b0}})) begin
            expected = W'(FIB_SEED);
        end else begin
            expected = g1_r + g2_r;
        end
    end

    // History shifts on the golden value, never on received data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_r <= {W{1'b0}};
            g2_r <= {W{1'b0}};
        end else if (clear) begin
            g1_r <= {W{1'b0}};
            g2_r <= {W{1'b0}};
        end else if (advance) begin
            g2_r <= g1_r;
            g1_r <= expected;
        end else begin
            g1_r <= g1_r;
            g2_r <= g2_r;
        end
    end

endmodule

// File: rtl/fib_stream_checker.sv
// Self-checking sink: compares an incoming Fibonacci stream against a golden
// model and reports pass/fail plus first-mismatch diagnostics after N samples.
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int W  = FIB_W_DEFAULT,
    parameter int N  = FIB_N_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [CW-1:0] sample_count,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] err_index,
    output logic [W-1:0]  err_expected,
    output logic [W-1:0]  err_actual,
    output logic          done,
    output logic          pass
);

    fib_state_t    state_r;
    fib_state_t    state_nxt_s;
    logic          accept_s;
    logic [W-1:0]  expected_s;
    logic [CW-1:0] count_nxt_s;
    logic          err_nxt_s;
    logic [CW-1:0] err_count_nxt_s;
    logic [CW-1:0] err_index_nxt_s;
    logic [W-1:0]  err_expected_nxt_s;
    logic [W-1:0]  err_actual_nxt_s;

    assign accept_s = in_valid & in_ready;

    fib_ref_model #(.W(W)) u_ref (
        .clk      (clk),
        .rst      (rst),
        .clear    (clr),
        .advance  (accept_s),
        .expected (expected_s)
    );

    // Next-state, counters and first-mismatch capture.
    always_comb begin
        state_nxt_s        = state_r;
        count_nxt_s        = sample_count;
        err_nxt_s          = err;
        err_count_nxt_s    = err_count;
        err_index_nxt_s    = err_index;
        err_expected_nxt_s = err_expected;
        err_actual_nxt_s   = err_actual;

        if (accept_s) begin
            count_nxt_s = sample_count + {{(CW-1){1'b0}}, 1'b1};
            if (in_data != expected_s) begin
                err_nxt_s = 1'b1;
                if (err_count != CW'(N)) begin
                    err_count_nxt_s = err_count + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    err_count_nxt_s = err_count;
                end
                if (!err) begin
                    err_index_nxt_s    = sample_count;
                    err_expected_nxt_s = expected_s;
                    err_actual_nxt_s   = in_data;
                end else begin
                    err_index_nxt_s    = err_index;
                    err_expected_nxt_s = err_expected;
                    err_actual_nxt_s   = err_actual;
                end
            end else begin
                err_nxt_s       = err;
                err_count_nxt_s = err_count;
            end
        end else begin
            count_nxt_s = sample_count;
        end

        case (state_r)
            SEED0: begin
                if (accept_s) state_nxt_s = SEED1;
                else          state_nxt_s = SEED0;
            end
            SEED1: begin
                if (accept_s) state_nxt_s = (N == 2) ? DONE : RUN;
                else          state_nxt_s = SEED1;
            end
            RUN: begin
                if (accept_s && (sample_count == CW'(N - 1))) state_nxt_s = DONE;
                else                                          state_nxt_s = RUN;
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = SEED0;
        endcase
    end

    // Status registers; clr has priority over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= SEED0;
            in_ready     <= 1'b1;
            sample_count <= {CW{1'b0}};
            err          <= 1'b0;
            err_count    <= {CW{1'b0}};
            err_index    <= {CW{1'b0}};
            err_expected <= {W{1'b0}};
            err_actual   <= {W{1'b0}};
            done         <= 1'b0;
            pass         <= 1'b0;
        end else if (clr) begin
            state_r      <= SEED0;
            in_ready     <= 1'b1;
            sample_count <= {CW{1'b0}};
            err          <= 1'b0;
            err_count    <= {CW{1'b0}};
            err_index    <= {CW{1'b0}};
            err_expected <= {W{1'b0}};
            err_actual   <= {W{1'b0}};
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            in_ready     <= (state_nxt_s != DONE);
            sample_count <= count_nxt_s;
            err          <= err_nxt_s;
            err_count    <= err_count_nxt_s;
            err_index    <= err_index_nxt_s;
            err_expected <= err_expected_nxt_s;
            err_actual   <= err_actual_nxt_s;
            done         <= (state_nxt_s == DONE);
            pass         <= (state_nxt_s == DONE) && (err_count_nxt_s == {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Randomized self-checking bench for fib_stream_checker against a plain
// arithmetic Fibonacci reference (W=4, N=10).
module tb_fib_stream_checker;

    localparam int W  = 4;
    localparam int N  = 10;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [CW-1:0] sample_count;
    logic          err;
    logic [CW-1:0] err_count;
    logic [CW-1:0] err_index;
    logic [W-1:0]  err_expected;
    logic [W-1:0]  err_actual;
    logic          done;
    logic          pass;

    int n_checks;
    int n_errors;

    logic [W-1:0] fib  [N];
    logic [W-1:0] stim [N];

    fib_stream_checker #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .sample_count (sample_count),
        .err          (err),
        .err_count    (err_count),
        .err_index    (err_index),
        .err_expected (err_expected),
        .err_actual   (err_actual),
        .done         (done),
        .pass         (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_cnt"},   sample_count, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_ecnt"},  err_count, 0);
        check({tag, "_eidx"},  err_index, 0);
        check({tag, "_eexp"},  err_expected, 0);
        check({tag, "_eact"},  err_actual, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_pass"},  pass, 0);
    endtask

    task automatic load_clean();
        for (int i = 0; i < N; i++) stim[i] = fib[i];
    endtask

    // Feed stim[first..last-1] with random idle gaps of 0..maxgap cycles.
    task automatic send(input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                @(posedge clk);
                @(negedge clk);
                check("stall_cnt", sample_count, i);
            end
            check("ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = stim[i];
            @(posedge clk);
            @(negedge clk);
            check("acc_cnt", sample_count, i + 1);
        end
        in_valid = 1'b0;
    endtask

    // Expected run result derived directly from stim versus the golden sequence.
    task automatic check_result(input string tag);
        int ec;
        int first;
        ec = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (stim[i] != fib[i]) begin
                ec++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_done"},  done, 1);
        check({tag, "_pass"},  pass, (ec == 0) ? 1 : 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_cnt"},   sample_count, N);
        check({tag, "_err"},   err, (ec != 0) ? 1 : 0);
        check({tag, "_ecnt"},  err_count, ec);
        check({tag, "_eidx"},  err_index, (first < 0) ? 0 : first);
        check({tag, "_eexp"},  err_expected, (first < 0) ? 0 : fib[first]);
        check({tag, "_eact"},  err_actual, (first < 0) ? 0 : stim[first]);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst");
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_reset("clr");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;

        fib[0] = 4'd1;
        fib[1] = 4'd1;
        for (int i = 2; i < N; i++) fib[i] = 4'((32'(fib[i-1]) + 32'(fib[i-2])) % 16);

        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Clean back-to-back stream.
        load_clean();
        send(0, N, 0);
        check_result("clean");

        // Same stream with random gaps.
        pulse_rst();
        send(0, N, 5);
        check_result("gaps");

        // Single corruption at index 4.
        pulse_rst();
        load_clean();
        stim[4] = 4'd6;
        send(0, N, 2);
        check_result("s4");
        check("s4_idx_const", err_index, 4);
        check("s4_act_const", err_actual, 6);

        // First sample wrong, later errors must not move the capture.
        pulse_clr();
        load_clean();
        stim[0] = 4'd0;
        stim[2] = fib[2] ^ 4'd9;
        stim[7] = fib[7] ^ 4'd3;
        send(0, N, 1);
        check_result("multi");
        check("multi_ecnt_const", err_count, 3);

        // Asynchronous reset mid-run.
        pulse_rst();
        load_clean();
        send(0, 5, 1);
        #2 rst = 1'b1;
        #1 check_reset("async");
        @(negedge clk);
        rst = 1'b0;
        send(0, N, 0);
        check_result("after_rst");

        // clr wins over a same-cycle accept.
        pulse_rst();
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = fib[0];
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_drop_cnt", sample_count, 0);
        check("clr_drop_err", err, 0);
        send(0, N, 0);
        check_result("clr_run");

        // Inputs ignored after done.
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_result("hold");
        end
        in_valid = 1'b0;
        pulse_clr();
        load_clean();
        send(0, N, 3);
        check_result("restart");

        // Random corruption runs.
        for (int r = 0; r < 6; r++) begin
            pulse_rst();
            for (int i = 0; i < N; i++) begin
                stim[i] = ($urandom_range(3, 0) == 0) ? 4'($urandom) : fib[i];
            end
            send(0, N, 4);
            check_result("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
